uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its byte/valid-pulse stream.
- Delimits command frames: header 0xAA 0x55, CMD, LEN, LEN payload bytes, CHK.
- Verifies the checksum and buffers the payload.
- Presents each good frame to the command dispatcher as a header handshake followed by a ready/valid payload stream.

---
 rtl/uart_cmd_parser.sv | 191 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames the UART RX byte stream into command packets.
//   Frame format: 0xAA 0x55 CMD LEN PAYLOAD[LEN] CHK, CHK = (CMD+LEN+payload) mod 256.
//   Good frames are presented as a header handshake (cmd_valid/cmd_ready with
//   cmd_code/cmd_len) followed by a ready/valid payload stream with payload_last.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        byte stream from the UART receiver
//   cmd_valid/ready/code/len header handshake towards the dispatcher
//   payload_valid/ready/data/last  payload stream towards the dispatcher
//   busy                     high whenever the parser is not hunting for 0xAA
//   err_chk/len/timeout/overrun    one-cycle error pulses
module uart_cmd_parser #(
    parameter int unsigned MAX_PAYLOAD  = 64,
    parameter int unsigned TIMEOUT_CLKS = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_len,
    output logic       payload_valid,
    input  logic       payload_ready,
    output logic [7:0] payload_data,
    output logic       payload_last,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    // Counter only needs to hold 0..TIMEOUT_CLKS-1.
    localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam bit            TMO_EN   = (TIMEOUT_CLKS != 0);
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        StHunt0, StHunt1, StCmd, StLen, StPayload, StCheck, StHdr, StPay
    } state_e;

    state_e          state_q;
    logic [7:0]      sum_q;
    logic [7:0]      wr_ptr_q;
    logic [7:0]      rd_ptr_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [7:0]      mem [MAX_PAYLOAD];

    logic [7:0]      rd_nxt;
    logic [AW-1:0]   rd_addr;
    logic            rx_phase;

    assign busy     = (state_q != StHunt0);
    assign rx_phase = (state_q == StCmd) || (state_q == StLen) ||
                      (state_q == StPayload) || (state_q == StCheck);
    assign rd_nxt   = rd_ptr_q + 8'd1;
    // Payload data is registered, so the RAM is read one beat ahead of the handshake.
    assign rd_addr  = (state_q == StHdr) ? '0 : rd_nxt[AW-1:0];

    // Payload buffer; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (state_q == StPayload && rx_valid) begin
            mem[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt0;
            sum_q         <= 8'd0;
            wr_ptr_q      <= 8'd0;
            rd_ptr_q      <= 8'd0;
            tmo_cnt_q     <= '0;
            cmd_valid     <= 1'b0;
            cmd_code      <= 8'd0;
            cmd_len       <= 8'd0;
            payload_valid <= 1'b0;
            payload_data  <= 8'd0;
            payload_last  <= 1'b0;
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            // Inter-byte timeout: counts idle cycles inside a frame only.
            if (rx_valid || !rx_phase) begin
                tmo_cnt_q <= '0;
            end else if (TMO_EN) begin
                if (tmo_cnt_q == TMO_LAST) begin
                    err_timeout <= 1'b1;
                    state_q     <= StHunt0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
            end

            unique case (state_q)
                StHunt0: begin
                    if (rx_valid && rx_data == 8'hAA) state_q <= StHunt1;
                end
                StHunt1: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h55)      state_q <= StCmd;
                        else if (rx_data != 8'hAA) state_q <= StHunt0;
                    end
                end
                StCmd: begin
                    if (rx_valid) begin
                        cmd_code <= rx_data;
                        sum_q    <= rx_data;
                        state_q  <= StLen;
                    end
                end
                StLen: begin
                    if (rx_valid) begin
                        cmd_len  <= rx_data;
                        sum_q    <= sum_q + rx_data;
                        wr_ptr_q <= 8'd0;
                        if (rx_data > MAX_LEN) begin
                            err_len <= 1'b1;
                            state_q <= StHunt0;
                        end else if (rx_data == 8'd0) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (rx_valid) begin
                        sum_q    <= sum_q + rx_data;
                        wr_ptr_q <= wr_ptr_q + 8'd1;
                        if (wr_ptr_q == cmd_len - 8'd1) state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
                            cmd_valid <= 1'b1;
                            state_q   <= StHdr;
                        end else begin
                            err_chk <= 1'b1;
                            state_q <= StHunt0;
                        end
                    end
                end
                StHdr: begin
                    // Bytes arriving while presenting are dropped.
                    err_overrun <= rx_valid;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (cmd_len == 8'd0) begin
                            state_q <= StHunt0;
                        end else begin
                            rd_ptr_q      <= 8'd0;
                            payload_valid <= 1'b1;
                            payload_data  <= mem[rd_addr];
                            payload_last  <= (cmd_len == 8'd1);
                            state_q       <= StPay;
                        end
                    end
                end
                StPay: begin
                    err_overrun <= rx_valid;
                    if (payload_ready) begin
                        if (payload_last) begin
                            payload_valid <= 1'b0;
                            payload_last  <= 1'b0;
                            state_q       <= StHunt0;
                        end else begin
                            rd_ptr_q     <= rd_nxt;
                            payload_data <= mem[rd_addr];
                            payload_last <= (rd_nxt == cmd_len - 8'd1);
                        end
                    end
                end
                default: state_q <= StHunt0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_code;
    logic [7:0] cmd_len;
    logic       payload_valid;
    logic       payload_ready;
    logic [7:0] payload_data;
    logic       payload_last;
    logic       busy;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    int n_vec = 0;
    int n_err = 0;

    // Pulse / beat counters, written only by the monitor below.
    int n_chk   = 0;
    int n_lenE  = 0;
    int n_to    = 0;
    int n_ovr   = 0;
    int n_beats = 0;

    uart_cmd_parser #(
        .MAX_PAYLOAD  (64),
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_code      (cmd_code),
        .cmd_len       (cmd_len),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .payload_data  (payload_data),
        .payload_last  (payload_last),
        .busy          (busy),
        .err_chk       (err_chk),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_chk)     n_chk  <= n_chk + 1;
        if (err_len)     n_lenE <= n_lenE + 1;
        if (err_timeout) n_to   <= n_to + 1;
        if (err_overrun) n_ovr  <= n_ovr + 1;
        if (payload_valid && payload_ready) n_beats <= n_beats + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_vec++;
        if ({cmd_valid, payload_valid, payload_last, busy, err_chk, err_len, err_timeout,
             err_overrun, cmd_code, cmd_len, payload_data} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b %b %h %h %h want all 0", cmd_valid, busy,
                     cmd_code, cmd_len, payload_data);
        end
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int b0;
        b0 = n_beats;
        cmd_ready = 1'b1;
        payload_ready = 1'b1;
        send(8'hAA); send(8'h55); send(8'h10); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_cmd_valid: got %b want 0", cmd_valid);
        end
        send(8'h19);  // 10+03+01+02+03
        n_vec++;
        if ({cmd_valid, cmd_code, cmd_len, busy} !== {1'b1, 8'h10, 8'h03, 1'b1}) begin
            n_err++;
            $display("FAIL basic_header: got v=%b code=%h len=%h busy=%b want 1 10 03 1",
                     cmd_valid, cmd_code, cmd_len, busy);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if ({cmd_valid, payload_valid, payload_data, payload_last} !==
                {1'b0, 1'b1, 8'(i), i == 3}) begin
                n_err++;
                $display("FAIL basic_beat%0d: got cv=%b pv=%b d=%h l=%b want 0 1 %h %b", i,
                         cmd_valid, payload_valid, payload_data, payload_last, 8'(i), i == 3);
            end
        end
        tick();
        n_vec++;
        if ({payload_valid, busy} !== 2'b00 || n_beats - b0 !== 3) begin
            n_err++;
            $display("FAIL basic_done: got pv=%b busy=%b beats=%0d want 0 0 3",
                     payload_valid, busy, n_beats - b0);
        end
    endtask

    task automatic test_zero_len();
        int b0;
        int c0;
        b0 = n_beats;
        c0 = n_chk;
        cmd_ready = 1'b0;
        send(8'hAA); send(8'h55); send(8'h20); send(8'h00); send(8'h20);
        tick(); tick();
        n_vec++;
        if ({cmd_valid, cmd_code, cmd_len} !== {1'b1, 8'h20, 8'h00}) begin
            n_err++;
            $display("FAIL zlen_header_held: got v=%b code=%h len=%h want 1 20 00",
                     cmd_valid, cmd_code, cmd_len);
        end
        cmd_ready = 1'b1;
        tick();
        n_vec++;
        if ({cmd_valid, payload_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL zlen_done: got cv=%b pv=%b busy=%b want 000", cmd_valid,
                     payload_valid, busy);
        end
        tick();
        n_vec++;
        if (n_beats - b0 !== 0) begin
            n_err++;
            $display("FAIL zlen_no_payload: got %0d beats want 0", n_beats - b0);
        end
        send(8'hAA); send(8'h55); send(8'h20); send(8'h00); send(8'h21);
        n_vec++;
        if ({err_chk, cmd_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL chk_pulse: got err_chk=%b cmd_valid=%b want 1 0", err_chk, cmd_valid);
        end
        tick();
        n_vec++;
        if ({err_chk, busy, cmd_valid} !== 3'b000 || n_chk - c0 !== 1) begin
            n_err++;
            $display("FAIL chk_after: got err_chk=%b busy=%b cv=%b count=%0d want 0 0 0 1",
                     err_chk, busy, cmd_valid, n_chk - c0);
        end
    endtask

    task automatic test_noise();
        send(8'h33); send(8'hAA); send(8'hAA); send(8'h55);
        send(8'h05); send(8'h01); send(8'h7E); send(8'h84);
        n_vec++;
        if ({cmd_valid, cmd_code, cmd_len} !== {1'b1, 8'h05, 8'h01}) begin
            n_err++;
            $display("FAIL noise_header: got v=%b code=%h len=%h want 1 05 01",
                     cmd_valid, cmd_code, cmd_len);
        end
        tick();
        n_vec++;
        if ({payload_valid, payload_data, payload_last} !== {1'b1, 8'h7E, 1'b1}) begin
            n_err++;
            $display("FAIL noise_payload: got v=%b d=%h l=%b want 1 7e 1", payload_valid,
                     payload_data, payload_last);
        end
        tick();
    endtask

    task automatic test_len_limit();
        logic [7:0] sum;
        int e0;
        e0 = n_lenE;
        send(8'hAA); send(8'h55); send(8'h01); send(8'h41);
        n_vec++;
        if ({err_len, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL len_reject: got err_len=%b busy=%b want 1 0", err_len, busy);
        end
        send(8'hAA); send(8'h55); send(8'h02); send(8'h01); send(8'h33); send(8'h36);
        n_vec++;
        if ({cmd_valid, cmd_code, n_lenE - e0 == 1} !== {1'b1, 8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL len_recover: got v=%b code=%h errs=%0d want 1 02 1", cmd_valid,
                     cmd_code, n_lenE - e0);
        end
        tick();
        tick();
        // LEN exactly MAX_PAYLOAD is accepted and fully delivered.
        sum = 8'h03 + 8'h40;
        send(8'hAA); send(8'h55); send(8'h03); send(8'h40);
        for (int i = 0; i < 64; i++) begin
            send(8'(i * 3 + 1));
            sum = sum + 8'(i * 3 + 1);
        end
        send(sum);
        n_vec++;
        if ({cmd_valid, cmd_len} !== {1'b1, 8'h40}) begin
            n_err++;
            $display("FAIL max_len_header: got v=%b len=%h want 1 40", cmd_valid, cmd_len);
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            n_vec++;
            if ({payload_valid, payload_data, payload_last} !== {1'b1, 8'(i * 3 + 1), i == 63})
            begin
                n_err++;
                $display("FAIL max_len_beat%0d: got v=%b d=%h l=%b want 1 %h %b", i,
                         payload_valid, payload_data, payload_last, 8'(i * 3 + 1), i == 63);
            end
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL max_len_done: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_to;
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h01);
        repeat (99) tick();
        n_vec++;
        if ({err_timeout, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL tmo_early: got err=%b busy=%b want 0 1", err_timeout, busy);
        end
        tick();
        n_vec++;
        if ({err_timeout, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL tmo_pulse: got err=%b busy=%b want 1 0", err_timeout, busy);
        end
        repeat (5) tick();
        n_vec++;
        if (n_to - t0 !== 1) begin
            n_err++;
            $display("FAIL tmo_once: got %0d pulses want 1", n_to - t0);
        end
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h01);
        repeat (99) tick();
        send(8'h02);
        repeat (99) tick();
        send(8'h06);
        n_vec++;
        if ({cmd_valid, cmd_code, cmd_len, n_to - t0 == 1} !== {1'b1, 8'h01, 8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL tmo_99_accept: got v=%b code=%h len=%h pulses=%0d want 1 01 02 1",
                     cmd_valid, cmd_code, cmd_len, n_to - t0);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        logic       pat [12];
        logic [7:0] sum;
        int idx;
        int o0;
        int b0;
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        o0 = n_ovr;
        b0 = n_beats;
        sum = 8'h07 + 8'h04;
        send(8'hAA); send(8'h55); send(8'h07); send(8'h04);
        for (int i = 0; i < 4; i++) begin
            send(exp_d[i]);
            sum = sum + exp_d[i];
        end
        send(sum);
        tick();
        idx = 0;
        for (int i = 0; i < 12 && idx < 4; i++) begin
            n_vec++;
            if ({payload_valid, payload_data, payload_last} !== {1'b1, exp_d[idx], idx == 3})
            begin
                n_err++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h l=%b want 1 %h %b", i,
                         payload_valid, payload_data, payload_last, exp_d[idx], idx == 3);
            end
            payload_ready = pat[i];
            if (i == 1 || i == 3) begin
                rx_data  = 8'hAA;
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            if (pat[i]) idx++;
        end
        payload_ready = 1'b1;
        tick();
        n_vec++;
        if (idx !== 4 || n_beats - b0 !== 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_delivery: got idx=%0d beats=%0d busy=%b want 4 4 0", idx,
                     n_beats - b0, busy);
        end
        n_vec++;
        if (n_ovr - o0 !== 2) begin
            n_err++;
            $display("FAIL overrun_count: got %0d want 2", n_ovr - o0);
        end
    endtask

    task automatic test_reset_mid_pay();
        int c0;
        c0 = n_chk + n_lenE + n_to + n_ovr;
        payload_ready = 1'b0;
        send(8'hAA); send(8'h55); send(8'h09); send(8'h02);
        send(8'h11); send(8'h22); send(8'h3E);
        tick();
        n_vec++;
        if (payload_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midpay_enter: got pv=%b want 1", payload_valid);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({cmd_valid, payload_valid, payload_last, busy, err_chk, err_len, err_timeout,
             err_overrun, cmd_code, cmd_len, payload_data} !== 32'd0) begin
            n_err++;
            $display("FAIL midpay_reset: got cv=%b pv=%b busy=%b code=%h d=%h want all 0",
                     cmd_valid, payload_valid, busy, cmd_code, payload_data);
        end
        tick();
        rst = 1'b0;
        payload_ready = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || n_chk + n_lenE + n_to + n_ovr !== c0) begin
            n_err++;
            $display("FAIL midpay_no_err: got busy=%b errs=%0d want 0 0", busy,
                     n_chk + n_lenE + n_to + n_ovr - c0);
        end
    endtask

    initial begin
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        cmd_ready     = 1'b0;
        payload_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_noise();
        test_len_limit();
        test_timeout();
        test_back_to_back();
        test_reset_mid_pay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
